// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared arbiter state type and default watchdog limit
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} arb_state_t;
  localparam int DEFAULT_TIMEOUT = 15;
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: 8-bit cycle counter with clear, enable and terminal-count flag
module mem_watchdog (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       tc
);
  logic [7:0] count;
  // count enabled cycles; clear wins over enable
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else count <= clr ? '0 : en ? count + 8'd1 : count;
  assign tc = count == limit;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between fetch and data requesters and drives the pipeline stall
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int MEMADDRWIDTH     = 16,
  parameter int TIMEOUT          = DEFAULT_TIMEOUT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        if_req,
  input  logic [MEMADDRWIDTH-1:0]     if_addr,
  output logic [INSTRUCTIONWIDTH-1:0] if_rdata,
  output logic                        if_valid,
  input  logic                        mem_req,
  input  logic                        mem_we,
  input  logic [MEMADDRWIDTH-1:0]     mem_addr,
  input  logic [WIDTH-1:0]            mem_wdata,
  output logic [WIDTH-1:0]            mem_rdata,
  output logic                        mem_valid,
  output logic                        stall,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [MEMADDRWIDTH-1:0]     ram_addr,
  output logic [WIDTH-1:0]            ram_wdata,
  input  logic [WIDTH-1:0]            ram_rdata,
  input  logic                        ram_ready,
  output logic                        timeout_err
);
  arb_state_t state, state_n;
  logic if_done, mem_done, go_i, go_d, busy, tc, fin, fin_i, fin_d;
  assign go_d  = mem_req & ~mem_done;
  assign go_i  = if_req & ~if_done;
  assign stall = go_i | go_d;
  assign busy  = state != IDLE;
  assign fin   = busy & (ram_ready | tc);
  assign fin_i = fin & (state == WAIT_I);
  assign fin_d = fin & (state == WAIT_D);
  mem_watchdog u_wdog (
    .clock (clock),
    .reset (reset),
    .clr   (~busy | fin),
    .en    (busy),
    .limit (8'(TIMEOUT)),
    .tc    (tc)
  );
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // data port first since it belongs to the older instruction; leave a wait state on completion or abort
  always_comb begin
    state_n = state;
    state_n = !busy ? (go_d ? WAIT_D : go_i ? WAIT_I : IDLE) : fin ? IDLE : state;
  end
  // RAM strobe and request latch, held stable for the whole wait
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= busy ? ~fin : (go_d | go_i);
      if (!busy && go_d) begin
        ram_we    <= mem_we;
        ram_addr  <= mem_addr;
        ram_wdata <= mem_wdata;
      end else if (!busy && go_i) begin
        ram_we   <= 1'b0;
        ram_addr <= if_addr;
      end
    end
  // completion: capture data (zero on abort), pulse valids, keep done flags until the pipeline advances
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      if_rdata    <= '0;
      mem_rdata   <= '0;
      if_valid    <= 1'b0;
      mem_valid   <= 1'b0;
      if_done     <= 1'b0;
      mem_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if_valid  <= fin_i;
      mem_valid <= fin_d;
      if_done   <= fin_i | (if_done & stall);
      mem_done  <= fin_d | (mem_done & stall);
      if (fin_i) if_rdata <= ram_ready ? ram_rdata[INSTRUCTIONWIDTH-1:0] : '0;
      if (fin_d && !ram_we) mem_rdata <= ram_ready ? ram_rdata : '0;
      if (fin && !ram_ready) timeout_err <= 1'b1;
    end
endmodule
